mux_scan: RTL and testbench
===========================

Name: mux_scan

Overview:
Parametrised, registered N-channel W-bit multiplexer with enable, the successor to the team's 8:1 combinational mux. It adds a second mode, auto-scan, in which an internal channel pointer steps through all channels. Each channel is held for a programmable number of cycles. The block drives one shared datapath from several sources, for example a sensor or display time-division bus. Outputs are registered and tagged with the channel index, a valid flag and a wrap pulse.

Parameters:
WIDTH, 8, bit width of each channel
CHANNELS, 8, number of input channels (>=2, need not be a power of 2)
DWELL, 1, enabled cycles spent on each channel in scan mode (>=1)
SELW, $clog2(CHANNELS), select/pointer width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  enable; 0 freezes the block
mode  input  1  0 = fixed select, 1 = auto-scan
sel  input  SELW  channel select in fixed mode, ignored in scan mode
din  input  CHANNELS*WIDTH  packed inputs; channel k = din[k*WIDTH +: WIDTH]
dout  output  WIDTH  registered selected data
dout_valid  output  1  dout holds a valid sample taken on the last cycle
ch_out  output  SELW  channel index that dout came from
wrap  output  1  one-cycle pulse; dout is the final dwell sample of channel CHANNELS-1 in scan mode

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset values: dout=0, dout_valid=0, ch_out=0, wrap=0, ptr=0, dwell_cnt=0. rst overrides en and mode.
- Latency: one cycle. Inputs sampled at edge t appear on the outputs after edge t.
- en=0: dout and ch_out hold their values. dout_valid<=0, wrap<=0. ptr and dwell_cnt are frozen.
- Fixed mode (mode=0, en=1):
  - sel<CHANNELS: dout<=din[sel], ch_out<=sel, dout_valid<=1.
  - sel>=CHANNELS (out of range): dout<=0, ch_out<=sel, dout_valid<=0.
  - wrap<=0.
  - ptr and dwell_cnt are forced to 0, so scan always restarts at channel 0.
- Scan mode (mode=1, en=1):
  - dout<=din[ptr], ch_out<=ptr, dout_valid<=1.
  - If dwell_cnt==DWELL-1: dwell_cnt<=0 and ptr advances. ptr goes to ptr+1, or to 0 when ptr==CHANNELS-1.
  - Otherwise dwell_cnt<=dwell_cnt+1.
  - wrap<=1 only when ptr==CHANNELS-1 and dwell_cnt==DWELL-1; otherwise wrap<=0.
- Pointer range: ptr never exceeds CHANNELS-1, including for non-power-of-2 CHANNELS.
- Mode switches:
  - scan->fixed takes effect on the same edge. That edge produces a fixed-mode output and zeroes ptr.
  - fixed->scan: the first scan output is channel 0 with a full DWELL.
- en dropped mid-dwell: on re-enable, scan resumes with the same ptr and the remaining dwell count. No sample is skipped or duplicated.
- Reset mid-scan: the next enabled scan output is channel 0.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, mode=1 and din nonzero -> dout=0, dout_valid=0, ch_out=0, wrap=0.
- Fixed mode, WIDTH=8, CHANNELS=8: din channel k = 8'h10+k; en=1, mode=0, sel stepped 0..7 -> one cycle later dout=8'h10+sel, ch_out=sel, dout_valid=1. Then en=0 -> dout holds 8'h17 and dout_valid=0.
- Scan, CHANNELS=8, DWELL=1: en=1, mode=1 for 16 cycles -> ch_out goes 0,1,…,7,0,…,7 and dout tracks 8'h10+ch_out. wrap=1 exactly on the two cycles where ch_out=7.
- Scan, CHANNELS=5, DWELL=2: 12 enabled cycles -> ch_out sequence 0,0,1,1,2,2,3,3,4,4,0,0. wrap=1 only on the second ch_out=4 cycle. ptr never reaches 5.
- Freeze and mode switch: scan to ch_out=3, then en=0 for 3 cycles -> outputs hold and dout_valid=0. Re-enable -> scan continues from the next channel. Switch mode=0 with sel=6 -> dout=8'h16. Switch back to mode=1 -> ch_out=0.
- Out of range, CHANNELS=5: mode=0, sel=7 -> dout=0, dout_valid=0, ch_out=7.

Source files
------------

// File: rtl/mux_scan_if.sv
// Bus bundle for mux_scan: channel inputs, select controls and tagged registered output.
interface mux_scan_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 8
);
  localparam int unsigned SELW = $clog2(CHANNELS);

  logic                      en;
  logic                      mode;
  logic [SELW-1:0]           sel;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [WIDTH-1:0]          dout;
  logic                      dout_valid;
  logic [SELW-1:0]           ch_out;
  logic                      wrap;

  modport master (
    output en, mode, sel, din,
    input  dout, dout_valid, ch_out, wrap
  );

  modport slave (
    input  en, mode, sel, din,
    output dout, dout_valid, ch_out, wrap
  );
endinterface

// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with fixed-select and auto-scan modes.
// Output is tagged with source channel, valid flag and an end-of-sweep wrap pulse.
module mux_scan #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned DWELL    = 1
) (
  input  logic       clk,
  input  logic       rst,
  mux_scan_if.slave  bus
);
  localparam int unsigned SELW = $clog2(CHANNELS);
  localparam int unsigned DCW  = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SELW-1:0] LAST_CH  = SELW'(CHANNELS - 1);
  localparam logic [DCW-1:0]  LAST_DW  = DCW'(DWELL - 1);
  localparam logic [SELW:0]   CH_LIMIT = (SELW + 1)'(CHANNELS);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             wrap_q, wrap_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [DCW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0] fixed_data;
  logic [WIDTH-1:0] scan_data;
  logic             sel_in_range;

  // Channel lookups; explicit compare loops keep out-of-range selects from indexing past din.
  always_comb begin
    fixed_data = '0;
    scan_data  = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (bus.sel == SELW'(k)) fixed_data = bus.din[k*WIDTH +: WIDTH];
      if (ptr_q   == SELW'(k)) scan_data  = bus.din[k*WIDTH +: WIDTH];
    end
    sel_in_range = ({1'b0, bus.sel} < CH_LIMIT);
  end

  // Next-state: hold when disabled, fixed select restarts the scan, scan walks ptr with dwell.
  always_comb begin
    dout_d  = dout_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (bus.en) begin
      if (!bus.mode) begin
        ptr_d = '0;
        cnt_d = '0;
        ch_d  = bus.sel;
        if (sel_in_range) begin
          dout_d  = fixed_data;
          valid_d = 1'b1;
        end else begin
          dout_d  = '0;
        end
      end else begin
        dout_d  = scan_data;
        ch_d    = ptr_q;
        valid_d = 1'b1;
        if (cnt_q == LAST_DW) begin
          cnt_d  = '0;
          ptr_d  = (ptr_q == LAST_CH) ? '0 : ptr_q + SELW'(1);
          wrap_d = (ptr_q == LAST_CH);
        end else begin
          cnt_d = cnt_q + DCW'(1);
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      wrap_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      wrap_q  <= wrap_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.ch_out     = ch_q;
  assign bus.wrap       = wrap_q;
endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: an 8-channel/dwell-1 and a 5-channel/dwell-2 instance driven in lockstep
// and compared every cycle against a sweep-position reference model.
module tb_mux_scan;
  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic [2:0]  sel;
  logic [63:0] din;

  int checks = 0;
  int errors = 0;

  mux_scan_if #(.WIDTH(8), .CHANNELS(8)) b8 ();
  mux_scan_if #(.WIDTH(8), .CHANNELS(5)) b5 ();

  assign b8.en   = en;
  assign b8.mode = mode;
  assign b8.sel  = sel;
  assign b8.din  = din;
  assign b5.en   = en;
  assign b5.mode = mode;
  assign b5.sel  = sel;
  assign b5.din  = din[39:0];

  mux_scan #(.WIDTH(8), .CHANNELS(8), .DWELL(1)) u8 (.clk(clk), .rst(rst), .bus(b8));
  mux_scan #(.WIDTH(8), .CHANNELS(5), .DWELL(2)) u5 (.clk(clk), .rst(rst), .bus(b5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Actual outputs gathered per instance: index 0 = 8ch/dwell1, 1 = 5ch/dwell2.
  logic [7:0] a_dout  [2];
  logic       a_valid [2];
  logic [2:0] a_ch    [2];
  logic       a_wrap  [2];
  always_comb begin
    a_dout[0] = b8.dout; a_valid[0] = b8.dout_valid; a_ch[0] = b8.ch_out; a_wrap[0] = b8.wrap;
    a_dout[1] = b5.dout; a_valid[1] = b5.dout_valid; a_ch[1] = b5.ch_out; a_wrap[1] = b5.wrap;
  end

  // Reference model: scan position counts enabled scan cycles since the last restart.
  logic [7:0]  m_dout  [2];
  logic        m_valid [2];
  logic [2:0]  m_ch    [2];
  logic        m_wrap  [2];
  int unsigned m_pos   [2];
  int unsigned m_nch   [2] = '{8, 5};
  int unsigned m_dwell [2] = '{1, 2};

  function automatic void model_step(input int k);
    int unsigned c, sweep;
    sweep = m_nch[k] * m_dwell[k];
    if (rst) begin
      m_dout[k] = 8'h00; m_valid[k] = 1'b0; m_ch[k] = 3'd0; m_wrap[k] = 1'b0; m_pos[k] = 0;
    end else if (!en) begin
      m_valid[k] = 1'b0; m_wrap[k] = 1'b0;
    end else if (!mode) begin
      m_pos[k]  = 0;
      m_wrap[k] = 1'b0;
      m_ch[k]   = sel;
      if (int'(sel) < int'(m_nch[k])) begin
        m_dout[k] = din[8*sel +: 8]; m_valid[k] = 1'b1;
      end else begin
        m_dout[k] = 8'h00; m_valid[k] = 1'b0;
      end
    end else begin
      c = (m_pos[k] / m_dwell[k]) % m_nch[k];
      m_dout[k]  = din[8*c +: 8];
      m_ch[k]    = 3'(c);
      m_valid[k] = 1'b1;
      m_wrap[k]  = (m_pos[k] == sweep - 1);
      m_pos[k]   = (m_pos[k] + 1) % sweep;
    end
  endfunction

  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 3'd3; din = 64'hA5C3_5A3C_9669_F00F;
    for (int i = 0; i < 2; i++) begin
      cycle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (a_dout[k] !== 8'h00 || a_valid[k] !== 1'b0 || a_ch[k] !== 3'd0 || a_wrap[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset[%0d] cyc%0d: got dout=%h v=%b ch=%0d w=%b, want all zero",
                   k, i, a_dout[k], a_valid[k], a_ch[k], a_wrap[k]);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    for (int k = 0; k < 8; k++) din[8*k +: 8] = 8'h10 + 8'(k);
    en = 1'b1; mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      cycle();
      checks++;
      if (b8.dout !== 8'h10 + 8'(s) || b8.ch_out !== 3'(s) || b8.dout_valid !== 1'b1 || b8.wrap !== 1'b0) begin
        errors++;
        $display("FAIL fixed8 sel=%0d: got dout=%h ch=%0d v=%b w=%b, want dout=%h ch=%0d v=1 w=0",
                 s, b8.dout, b8.ch_out, b8.dout_valid, b8.wrap, 8'h10 + 8'(s), s);
      end
      checks++;
      if (a_dout[1] !== m_dout[1] || a_valid[1] !== m_valid[1] || a_ch[1] !== m_ch[1] || a_wrap[1] !== m_wrap[1]) begin
        errors++;
        $display("FAIL fixed5 sel=%0d: got dout=%h v=%b ch=%0d w=%b, want dout=%h v=%b ch=%0d w=%b",
                 s, a_dout[1], a_valid[1], a_ch[1], a_wrap[1], m_dout[1], m_valid[1], m_ch[1], m_wrap[1]);
      end
    end
    en = 1'b0;
    cycle();
    checks++;
    if (b8.dout !== 8'h17 || b8.dout_valid !== 1'b0 || b8.ch_out !== 3'd7) begin
      errors++;
      $display("FAIL fixed_hold: got dout=%h v=%b ch=%0d, want dout=17 v=0 ch=7", b8.dout, b8.dout_valid, b8.ch_out);
    end
  endtask

  task automatic test_scan();
    int exp5 [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0};
    en = 1'b1; mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      checks++;
      if (b8.ch_out !== 3'(i % 8) || b8.dout !== 8'h10 + 8'(i % 8) || b8.dout_valid !== 1'b1 ||
          b8.wrap !== ((i % 8) == 7)) begin
        errors++;
        $display("FAIL scan8 i=%0d: got ch=%0d dout=%h v=%b w=%b, want ch=%0d dout=%h v=1 w=%b",
                 i, b8.ch_out, b8.dout, b8.dout_valid, b8.wrap, i % 8, 8'h10 + 8'(i % 8), (i % 8) == 7);
      end
      if (i < 12) begin
        checks++;
        if (b5.ch_out !== 3'(exp5[i]) || b5.dout !== 8'h10 + 8'(exp5[i]) || b5.wrap !== (i == 9)) begin
          errors++;
          $display("FAIL scan5 i=%0d: got ch=%0d dout=%h w=%b, want ch=%0d dout=%h w=%b",
                   i, b5.ch_out, b5.dout, b5.wrap, exp5[i], 8'h10 + 8'(exp5[i]), i == 9);
        end
      end
      checks++;
      if (a_dout[1] !== m_dout[1] || a_valid[1] !== m_valid[1] || a_ch[1] !== m_ch[1] || a_wrap[1] !== m_wrap[1]) begin
        errors++;
        $display("FAIL scan5_model i=%0d: got dout=%h v=%b ch=%0d w=%b, want dout=%h v=%b ch=%0d w=%b",
                 i, a_dout[1], a_valid[1], a_ch[1], a_wrap[1], m_dout[1], m_valid[1], m_ch[1], m_wrap[1]);
      end
    end
  endtask

  task automatic test_freeze_switch();
    int step = 0;
    rst = 1'b1;
    cycle();
    rst = 1'b0; en = 1'b1; mode = 1'b1;
    repeat (4) cycle();
    checks++;
    if (b8.ch_out !== 3'd3 || b8.dout !== 8'h13) begin
      errors++;
      $display("FAIL freeze_pre: got ch=%0d dout=%h, want ch=3 dout=13", b8.ch_out, b8.dout);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (b8.ch_out !== 3'd3 || b8.dout !== 8'h13 || b8.dout_valid !== 1'b0 || b8.wrap !== 1'b0) begin
        errors++;
        $display("FAIL freeze_hold i=%0d: got ch=%0d dout=%h v=%b w=%b, want ch=3 dout=13 v=0 w=0",
                 i, b8.ch_out, b8.dout, b8.dout_valid, b8.wrap);
      end
    end
    // Steps: resume scan, fixed sel=6, back to scan.
    for (step = 0; step < 3; step++) begin
      en = 1'b1;
      mode = (step != 1);
      sel = 3'd6;
      cycle();
      checks++;
      if ((step == 0 && (b8.ch_out !== 3'd4 || b8.dout !== 8'h14 || b8.dout_valid !== 1'b1)) ||
          (step == 1 && (b8.ch_out !== 3'd6 || b8.dout !== 8'h16 || b8.dout_valid !== 1'b1)) ||
          (step == 2 && (b8.ch_out !== 3'd0 || b8.dout !== 8'h10 || b8.dout_valid !== 1'b1))) begin
        errors++;
        $display("FAIL switch step=%0d: got ch=%0d dout=%h v=%b, want ch=%0d dout=%h v=1",
                 step, b8.ch_out, b8.dout, b8.dout_valid,
                 (step == 0) ? 4 : (step == 1) ? 6 : 0, (step == 0) ? 8'h14 : (step == 1) ? 8'h16 : 8'h10);
      end
      checks++;
      if (a_dout[1] !== m_dout[1] || a_valid[1] !== m_valid[1] || a_ch[1] !== m_ch[1] || a_wrap[1] !== m_wrap[1]) begin
        errors++;
        $display("FAIL switch5 step=%0d: got dout=%h v=%b ch=%0d w=%b, want dout=%h v=%b ch=%0d w=%b",
                 step, a_dout[1], a_valid[1], a_ch[1], a_wrap[1], m_dout[1], m_valid[1], m_ch[1], m_wrap[1]);
      end
    end
  endtask

  task automatic test_out_of_range();
    en = 1'b1; mode = 1'b0;
    for (int s = 5; s < 8; s++) begin
      sel = 3'(s);
      cycle();
      checks++;
      if (b5.dout !== 8'h00 || b5.dout_valid !== 1'b0 || b5.ch_out !== 3'(s) || b5.wrap !== 1'b0) begin
        errors++;
        $display("FAIL out_of_range sel=%0d: got dout=%h v=%b ch=%0d w=%b, want dout=00 v=0 ch=%0d w=0",
                 s, b5.dout, b5.dout_valid, b5.ch_out, b5.wrap, s);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 29) == 0);
      en   = ($urandom_range(0, 9) < 8);
      mode = ($urandom_range(0, 9) < 7);
      sel  = 3'($urandom);
      din  = {$urandom, $urandom};
      cycle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (a_dout[k] !== m_dout[k] || a_valid[k] !== m_valid[k] || a_ch[k] !== m_ch[k] || a_wrap[k] !== m_wrap[k]) begin
          errors++;
          $display("FAIL random[%0d] i=%0d: got dout=%h v=%b ch=%0d w=%b, want dout=%h v=%b ch=%0d w=%b",
                   k, i, a_dout[k], a_valid[k], a_ch[k], a_wrap[k], m_dout[k], m_valid[k], m_ch[k], m_wrap[k]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; din = '0;
    test_reset();
    test_fixed();
    test_scan();
    test_freeze_switch();
    test_out_of_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
